// File: rtl/multirate_fifo.sv
// Single-clock FIFO that accepts K words per write and delivers J words per read.
// Reads are first-word fall-through; a peak register tracks the highest fill level.
module multirate_fifo #(
   parameter int unsigned SIZE     = 16,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned K        = 4,
   parameter int unsigned J        = 4,
   parameter int unsigned AF_LEVEL = SIZE - K
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wr_valid,
   input  logic [WIDTH*K-1:0]         wr_data,
   output logic                       wr_ready,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [WIDTH*J-1:0]         rd_data,
   output logic [$clog2(SIZE):0]      count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic [$clog2(SIZE):0]      peak
);

   localparam int unsigned PtrW = $clog2(SIZE);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [PtrW-1:0] WrStep = PtrW'(K % SIZE);
   localparam logic [PtrW-1:0] RdStep = PtrW'(J % SIZE);
   localparam bit AfEn = (AF_LEVEL <= SIZE);

   logic [WIDTH-1:0] mem_q [SIZE];
   logic [PtrW-1:0]  wp_q, wp_d;
   logic [PtrW-1:0]  rp_q, rp_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [CntW-1:0]  peak_q, peak_d;
   logic             wr_acc, rd_acc;
   logic [CntW-1:0]  add_k, sub_j;

   // Handshake flags come straight from the registered count.
   assign wr_ready    = (CntW'(SIZE) - count_q) >= CntW'(K);
   assign rd_valid    = count_q >= CntW'(J);
   assign full        = ~wr_ready;
   assign empty       = ~rd_valid;
   assign almost_full = AfEn && (count_q >= CntW'(AF_LEVEL));
   assign count       = count_q;
   assign peak        = peak_q;

   assign wr_acc = wr_valid && wr_ready;
   assign rd_acc = rd_valid && rd_ready;

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < int'(J); i++) begin
         rd_data[i*WIDTH +: WIDTH] = mem_q[rp_q + PtrW'(i)];
      end
   end

   always_comb begin
      add_k   = wr_acc ? CntW'(K) : '0;
      sub_j   = rd_acc ? CntW'(J) : '0;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q + add_k - sub_j;
      if (wr_acc) wp_d = wp_q + WrStep;
      if (rd_acc) rp_d = rp_q + RdStep;
      peak_d  = (count_d > peak_q) ? count_d : peak_q;
      // Flush wins over any transfer offered in the same cycle.
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
         peak_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         peak_q  <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         peak_q  <= peak_d;
      end
   end

   // Storage is left untouched by flush; only pointers are cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(SIZE); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_acc && !flush) begin
         for (int i = 0; i < int'(K); i++) begin
            mem_q[wp_q + PtrW'(i)] <= wr_data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_multirate_fifo.sv
// Directed self-checking bench for multirate_fifo with SIZE=16, WIDTH=8, K=4, J=2, AF_LEVEL=12.
module tb_multirate_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [15:0] rd_data;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic [4:0]  peak;

   int total = 0;
   int bad = 0;

   multirate_fifo #(
      .SIZE(16), .WIDTH(8), .K(4), .J(2), .AF_LEVEL(12)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .peak(peak)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wd(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   function automatic logic [7:0] wrap_seq(input int n);
      return (n < 10) ? 8'(8'h26 + n) : 8'(8'h30 + n - 10);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] b);
      wr_valid = 1'b1;
      wr_data  = wd(b);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic rd();
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_count", count, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_af", almost_full, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_peak", peak, 0);
      step();
      step();
      rst = 1'b0;

      // Basic write then two reads
      wr(8'h00);
      chk("w1_count", count, 4);
      chk("w1_rd_valid", rd_valid, 1);
      chk("w1_rd_data", rd_data, 16'h0100);
      rd();
      chk("r1_rd_data", rd_data, 16'h0302);
      chk("r1_count", count, 2);
      rd();
      chk("r2_count", count, 0);
      chk("r2_empty", empty, 1);
      chk("r2_peak", peak, 4);

      // Fill to capacity, fifth write refused
      for (int i = 0; i < 4; i++) wr(8'(8'h10 + 4 * i));
      chk("fill_count", count, 16);
      chk("fill_full", full, 1);
      chk("fill_wr_ready", wr_ready, 0);
      chk("fill_af", almost_full, 1);
      chk("fill_peak", peak, 16);
      wr(8'hA0);
      chk("ovf_count", count, 16);
      chk("ovf_wp", dut.wp_q, 4);
      chk("ovf_rd_data", rd_data, 16'h1110);

      // Wrap across address 15 -> 0 from a clean reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) wr(8'(8'h20 + 4 * i));
      for (int i = 0; i < 3; i++) begin
         chk("wrap_pre_rd", rd_data, {8'(8'h21 + 2 * i), 8'(8'h20 + 2 * i)});
         rd();
      end
      chk("wrap_af_off", almost_full, 0);
      wr(8'h30);
      chk("wrap_wp", dut.wp_q, 4);
      chk("wrap_rp", dut.rp_q, 6);
      chk("wrap_count", count, 14);
      for (int i = 0; i < 7; i++) begin
         chk("wrap_rd", rd_data, {wrap_seq(2 * i + 1), wrap_seq(2 * i)});
         rd();
      end
      chk("wrap_empty_count", count, 0);

      // Simultaneous write and read at count=6
      wr(8'h40);
      wr(8'h44);
      rd();
      chk("sim_pre_count", count, 6);
      chk("sim_pre_data", rd_data, 16'h4342);
      wr_valid = 1'b1;
      wr_data  = wd(8'h48);
      rd_ready = 1'b1;
      step();
      chk("sim_count", count, 8);
      chk("sim_data", rd_data, 16'h4544);
      wr_data = wd(8'h4C);
      step();
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      chk("sim2_count", count, 10);
      chk("sim2_data", rd_data, 16'h4746);

      // Flush overrides write and read
      chk("pre_flush_peak", peak, 16);
      flush    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = wd(8'hB0);
      rd_ready = 1'b1;
      step();
      flush    = 1'b0;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_peak", peak, 0);
      chk("flush_wp", dut.wp_q, 0);
      chk("flush_rp", dut.rp_q, 0);
      chk("flush_empty", empty, 1);

      // Asynchronous reset between edges at count=8
      wr(8'h50);
      wr(8'h54);
      chk("ar_pre_count", count, 8);
      chk("ar_pre_data", rd_data, 16'h5150);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_count", count, 0);
      chk("ar_rd_valid", rd_valid, 0);
      chk("ar_rd_data", rd_data, 0);
      chk("ar_wr_ready", wr_ready, 1);
      #1;
      rst = 1'b0;
      wr(8'h60);
      chk("ar_post_wp", dut.wp_q, 4);
      chk("ar_post_data", rd_data, 16'h6160);
      chk("ar_post_count", count, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
